// File: rtl/umi_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// umi_tx_serializer_if
// Bundles the packet-side and link-side handshake signals of the UMI TX
// serializer.
//   slave  : the serializer itself (accepts packets, drives link words)
//   master : the environment (offers packets, accepts link words)
// Signals:
//   umi_in_valid / umi_in_packet / umi_in_ready : PW-bit packet handshake
//   io_valid / io_data / io_first / io_last / io_ready : IOW-bit link handshake
//   busy : a packet is in flight
// ---------------------------------------------------------------------------
interface umi_tx_serializer_if #(
    parameter int PW  = 256,
    parameter int IOW = 64
);
    logic          umi_in_valid;
    logic [PW-1:0] umi_in_packet;
    logic          umi_in_ready;
    logic          io_valid;
    logic [IOW-1:0] io_data;
    logic          io_first;
    logic          io_last;
    logic          io_ready;
    logic          busy;

    modport slave (
        input  umi_in_valid,
        input  umi_in_packet,
        output umi_in_ready,
        output io_valid,
        output io_data,
        output io_first,
        output io_last,
        input  io_ready,
        output busy
    );

    modport master (
        output umi_in_valid,
        output umi_in_packet,
        input  umi_in_ready,
        input  io_valid,
        input  io_data,
        input  io_first,
        input  io_last,
        output io_ready,
        input  busy
    );
endinterface

// File: rtl/umi_tx_serializer.sv
// ---------------------------------------------------------------------------
// umi_tx_serializer
// Splits a PW-bit UMI packet into N = PW/IOW link words, least-significant
// word first, with first/last markers and valid/ready flow control on both
// sides. A new packet can be accepted in the same cycle the last word of the
// current one handshakes, so back-to-back packets stream without a bubble.
// Ports:
//   clk    : clock
//   nreset : asynchronous active-low reset
//   bus    : umi_tx_serializer_if.slave (packet input, link output, busy)
// ---------------------------------------------------------------------------
module umi_tx_serializer #(
    parameter int PW  = 256,
    parameter int IOW = 64
) (
    input  logic                  clk,
    input  logic                  nreset,
    umi_tx_serializer_if.slave    bus
);

    localparam int N  = PW / IOW;
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(N - 1);
    localparam logic [BW-1:0] BEAT_PENU = BW'((N > 1) ? N - 2 : 0);

    generate
        if ((PW % IOW) != 0 || N < 2) begin : g_illegal_cfg
            $error("umi_tx_serializer: PW must be an integer multiple of IOW with PW/IOW >= 2");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state;
    logic [PW-1:0]  shreg;
    logic [BW-1:0]  beat;
    logic           first_q;
    logic           last_q;

    logic           last_beat;
    logic           in_hs;

    assign last_beat = (beat == BEAT_LAST);

    // Ready is combinational from io_ready so the next packet can be taken
    // on the same edge the final word leaves.
    assign bus.umi_in_ready = (state == IDLE) | ((state == SEND) & last_beat & bus.io_ready);
    assign in_hs            = bus.umi_in_valid & bus.umi_in_ready;

    assign bus.io_valid = (state == SEND);
    assign bus.busy     = (state == SEND);
    assign bus.io_data  = (state == SEND) ? shreg[IOW-1:0] : '0;
    assign bus.io_first = first_q;
    assign bus.io_last  = last_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            shreg   <= '0;
            beat    <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // io_ready is ignored here; only a new packet moves us on.
                    if (in_hs) begin
                        state   <= SEND;
                        shreg   <= bus.umi_in_packet;
                        beat    <= '0;
                        first_q <= 1'b1;
                        last_q  <= 1'b0;
                    end
                end
                SEND: begin
                    if (bus.io_ready) begin
                        if (last_beat) begin
                            if (in_hs) begin
                                shreg   <= bus.umi_in_packet;
                                beat    <= '0;
                                first_q <= 1'b1;
                                last_q  <= 1'b0;
                            end else begin
                                state   <= IDLE;
                                shreg   <= '0;
                                beat    <= '0;
                                first_q <= 1'b0;
                                last_q  <= 1'b0;
                            end
                        end else begin
                            shreg   <= shreg >> IOW;
                            beat    <= beat + 1'b1;
                            first_q <= 1'b0;
                            // Marker is registered one beat ahead so io_last
                            // comes straight from a flop.
                            last_q  <= (beat == BEAT_PENU);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_umi_tx_serializer.sv
module tb_umi_tx_serializer;

    localparam int PW  = 256;
    localparam int IOW = 64;
    localparam int N   = PW / IOW;

    typedef struct {
        logic [IOW-1:0] d;
        bit             first;
        bit             last;
    } word_t;

    logic clk;
    logic nreset;

    umi_tx_serializer_if #(.PW(PW), .IOW(IOW)) bus ();

    umi_tx_serializer #(.PW(PW), .IOW(IOW)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    passed = 0;
    int    total  = 0;
    int    fails  = 0;
    word_t q[$];

    task automatic check(input string tag, input logic [IOW-1:0] obs, input logic [IOW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: a queue of words still owed to the link. Ready is the
    // condition "nothing owed, or only the final word owed and it leaves now".
    task automatic do_cycle(input string tag);
        logic           ev, ef, el, er;
        logic [IOW-1:0] ed;
        word_t          w;
        ev = (q.size() != 0);
        ed = ev ? q[0].d : '0;
        ef = ev ? q[0].first : 1'b0;
        el = ev ? q[0].last : 1'b0;
        er = (q.size() == 0) || (q.size() == 1 && bus.io_ready);
        #1;
        check({tag, ".io_valid"}, IOW'(bus.io_valid), IOW'(ev));
        check({tag, ".io_data"}, bus.io_data, ed);
        check({tag, ".io_first"}, IOW'(bus.io_first), IOW'(ef));
        check({tag, ".io_last"}, IOW'(bus.io_last), IOW'(el));
        check({tag, ".in_ready"}, IOW'(bus.umi_in_ready), IOW'(er));
        check({tag, ".busy"}, IOW'(bus.busy), IOW'(ev));
        @(posedge clk);
        if (bus.io_ready && q.size() != 0) void'(q.pop_front());
        if (bus.umi_in_valid && er) begin
            for (int k = 0; k < N; k++) begin
                w.d     = bus.umi_in_packet[k*IOW +: IOW];
                w.first = (k == 0);
                w.last  = (k == N - 1);
                q.push_back(w);
            end
        end
        #1;
    endtask

    function automatic logic [PW-1:0] rand_pkt();
        logic [PW-1:0] p;
        for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    int vcount;

    initial begin
        nreset            = 1'b0;
        bus.umi_in_valid  = 1'b0;
        bus.umi_in_packet = '0;
        bus.io_ready      = 1'b0;
        #3;
        check("rst.io_valid", IOW'(bus.io_valid), '0);
        check("rst.io_data", bus.io_data, '0);
        check("rst.io_first", IOW'(bus.io_first), '0);
        check("rst.io_last", IOW'(bus.io_last), '0);
        check("rst.busy", IOW'(bus.busy), '0);
        check("rst.in_ready", IOW'(bus.umi_in_ready), IOW'(1));
        @(posedge clk);
        #1;
        nreset = 1'b1;

        // Single packet with the link always ready
        bus.io_ready      = 1'b1;
        bus.umi_in_valid  = 1'b1;
        bus.umi_in_packet = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
        do_cycle("single.accept");
        bus.umi_in_valid  = 1'b0;
        bus.umi_in_packet = rand_pkt();
        for (int i = 0; i < 5; i++) do_cycle("single");

        // Backpressure for 3 cycles while beat 1 is shown
        bus.umi_in_valid  = 1'b1;
        bus.umi_in_packet = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
        do_cycle("bp.accept");
        bus.umi_in_valid  = 1'b0;
        do_cycle("bp.beat0");
        bus.io_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_cycle("bp.stall");
            check("bp.hold_data", bus.io_data, 64'h2222);
        end
        bus.io_ready = 1'b1;
        for (int i = 0; i < 4; i++) do_cycle("bp.resume");

        // Back-to-back: two packets with no gap
        vcount = 0;
        bus.umi_in_valid  = 1'b1;
        bus.umi_in_packet = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
        do_cycle("b2b.accept0");
        bus.umi_in_packet = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus.umi_in_valid = 1'b0;
            if (bus.io_valid) vcount++;
            do_cycle("b2b");
        end
        check("b2b.valid_words", IOW'(vcount), IOW'(8));
        do_cycle("b2b.idle");

        // Input stall: new packet held while beat 1 is backpressured
        bus.umi_in_valid  = 1'b1;
        bus.umi_in_packet = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        do_cycle("stall.accept");
        bus.umi_in_packet = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
        do_cycle("stall.beat0");
        bus.io_ready = 1'b0;
        for (int i = 0; i < 3; i++) do_cycle("stall.hold");
        bus.io_ready = 1'b1;
        for (int i = 0; i < 3; i++) do_cycle("stall.drain");
        bus.umi_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) do_cycle("stall.next");

        // Asynchronous reset while beat 2 is shown
        bus.umi_in_valid  = 1'b1;
        bus.umi_in_packet = {64'hF3, 64'hF2, 64'hF1, 64'hF0};
        do_cycle("rstmid.accept");
        bus.umi_in_valid = 1'b0;
        do_cycle("rstmid.beat0");
        do_cycle("rstmid.beat1");
        check("rstmid.beat2_data", bus.io_data, 64'hF2);
        nreset = 1'b0;
        #1;
        check("rstmid.io_valid", IOW'(bus.io_valid), '0);
        check("rstmid.busy", IOW'(bus.busy), '0);
        check("rstmid.in_ready", IOW'(bus.umi_in_ready), IOW'(1));
        q.delete();
        @(posedge clk);
        #1;
        nreset = 1'b1;
        bus.umi_in_valid  = 1'b1;
        bus.umi_in_packet = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        do_cycle("rstmid.newpkt");
        bus.umi_in_valid = 1'b0;
        check("rstmid.new_first", IOW'(bus.io_first), IOW'(1));
        check("rstmid.new_word0", bus.io_data, 64'hA0);
        for (int i = 0; i < 5; i++) do_cycle("rstmid.drain");

        // Randomized traffic, packet bus changes every cycle
        for (int i = 0; i < 300; i++) begin
            bus.umi_in_valid  = ($urandom_range(0, 3) != 0);
            bus.io_ready      = ($urandom_range(0, 3) != 0);
            bus.umi_in_packet = rand_pkt();
            do_cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
